// File: rtl/spi_slave_if.sv
// SPI slave serial front end: frames MOSI bits into command+data words
// for the RAM and shifts RAM read data back out on MISO.
module spi_slave_if #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              SS_n,
   input  logic              MOSI,
   output logic              MISO,
   output logic [DATA_W+1:0] rx_data,
   output logic              rx_valid,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid
);

   localparam int FRAME_W = DATA_W + 2;
   localparam int CNT_W   = $clog2(FRAME_W + 3);
   localparam int OCNT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   // bit_cnt past the last frame bit doubles as the post-frame phase
   localparam logic [CNT_W-1:0]  LAST    = CNT_W'(FRAME_W - 1);
   localparam logic [CNT_W-1:0]  PH_WAIT = CNT_W'(FRAME_W);
   localparam logic [CNT_W-1:0]  PH_SEND = CNT_W'(FRAME_W + 1);
   localparam logic [CNT_W-1:0]  PH_DONE = CNT_W'(FRAME_W + 2);
   localparam logic [OCNT_W-1:0] OLAST   = OCNT_W'(DATA_W - 1);

   typedef enum logic [2:0] {
      IDLE,
      CHK_CMD,
      WRITE,
      READ_ADD,
      READ_DATA
   } state_t;

   state_t              state;
   logic [FRAME_W-1:0]  sh_in;
   logic [CNT_W-1:0]    bit_cnt;
   logic [DATA_W-1:0]   sh_out;
   logic [OCNT_W-1:0]   out_cnt;
   logic                rd_addr_seen;
   logic [FRAME_W-1:0]  frame;

   assign frame = {sh_in[FRAME_W-2:0], MOSI};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         sh_in        <= '0;
         bit_cnt      <= '0;
         sh_out       <= '0;
         out_cnt      <= '0;
         rd_addr_seen <= 1'b0;
         MISO         <= 1'b0;
         rx_data      <= '0;
         rx_valid     <= 1'b0;
      end else begin
         rx_valid <= 1'b0;
         if (state != IDLE && SS_n) begin
            state   <= IDLE;
            sh_in   <= '0;
            bit_cnt <= '0;
            sh_out  <= '0;
            out_cnt <= '0;
            MISO    <= 1'b0;
         end else begin
            unique case (state)
               IDLE: begin
                  if (!SS_n) state <= CHK_CMD;
               end
               CHK_CMD: begin
                  sh_in   <= frame;
                  bit_cnt <= CNT_W'(1);
                  if (!MOSI)
                     state <= WRITE;
                  else if (rd_addr_seen)
                     state <= READ_DATA;
                  else
                     state <= READ_ADD;
               end
               WRITE, READ_ADD, READ_DATA: begin
                  if (bit_cnt < LAST) begin
                     sh_in   <= frame;
                     bit_cnt <= bit_cnt + 1'b1;
                  end else if (bit_cnt == LAST) begin
                     sh_in    <= frame;
                     rx_data  <= frame;
                     rx_valid <= 1'b1;
                     bit_cnt  <= PH_WAIT;
                     if (state == READ_ADD) rd_addr_seen <= 1'b1;
                  end else if (state == READ_DATA) begin
                     if (bit_cnt == PH_WAIT && tx_valid) begin
                        sh_out  <= tx_data << 1;
                        MISO    <= tx_data[DATA_W-1];
                        out_cnt <= '0;
                        bit_cnt <= PH_SEND;
                     end else if (bit_cnt == PH_SEND) begin
                        if (out_cnt == OLAST) begin
                           MISO         <= 1'b0;
                           rd_addr_seen <= 1'b0;
                           bit_cnt      <= PH_DONE;
                        end else begin
                           MISO    <= sh_out[DATA_W-1];
                           sh_out  <= sh_out << 1;
                           out_cnt <= out_cnt + 1'b1;
                        end
                     end
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_spi_slave_if.sv
// Randomised bench for spi_slave_if against a transaction-level model
// of frame reception, read-address tracking and MISO shift-out.
module tb_spi_slave_if;

   logic       clk = 1'b0;
   logic       rst;
   logic       SS_n;
   logic       MOSI;
   logic       MISO;
   logic [9:0] rx_data;
   logic       rx_valid;
   logic [7:0] tx_data;
   logic       tx_valid;

   int         total = 0;
   int         bad = 0;
   bit         rd_seen = 1'b0;
   logic [9:0] last_rx = '0;

   spi_slave_if #(.DATA_W(8)) dut (
      .clk      (clk),
      .rst      (rst),
      .SS_n     (SS_n),
      .MOSI     (MOSI),
      .MISO     (MISO),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .tx_data  (tx_data),
      .tx_valid (tx_valid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   function automatic logic rb();
      return ($urandom() % 2) == 1;
   endfunction

   task automatic tick(input logic ss, input logic mosi, input logic tv,
                       input logic [7:0] td);
      @(negedge clk);
      SS_n     = ss;
      MOSI     = mosi;
      tx_valid = tv;
      tx_data  = td;
      @(posedge clk);
      #1;
   endtask

   task automatic quiet(input string tag);
      chk({tag, "_rxv"}, 32'(rx_valid), 32'd0);
      chk({tag, "_miso"}, 32'(MISO), 32'd0);
   endtask

   // mode: 0 normal, 1 abort while waiting for tx_valid,
   // 2 abort after k MISO bits, 3 async reset after k MISO bits
   task automatic run_txn(input logic [9:0] frame, input int abort_bit,
                          input int stray, input int wait_d,
                          input int mode, input int k,
                          input logic [7:0] txd);
      int kind;
      kind = !frame[9] ? 0 : (rd_seen ? 2 : 1);
      tick(1'b0, rb(), rb(), 8'($urandom()));
      quiet("e0");
      for (int i = 0; i < 10; i++) begin
         if (i == abort_bit) begin
            tick(1'b1, rb(), rb(), 8'($urandom()));
            quiet("abort");
            chk("abort_rxd", 32'(rx_data), 32'(last_rx));
            return;
         end
         tick(1'b0, frame[9-i], i == stray, 8'($urandom()));
         chk("rx_valid", 32'(rx_valid), 32'(i == 9));
         chk("rx_miso", 32'(MISO), 32'd0);
      end
      chk("rx_data", 32'(rx_data), 32'(frame));
      last_rx = frame;
      if (kind == 1) rd_seen = 1'b1;
      if (kind != 2) begin
         repeat ($urandom_range(0, 3)) begin
            tick(1'b0, rb(), rb(), 8'($urandom()));
            quiet("hold");
            chk("hold_rxd", 32'(rx_data), 32'(frame));
         end
         return;
      end
      repeat (wait_d) begin
         tick(1'b0, rb(), 1'b0, 8'($urandom()));
         quiet("wait");
      end
      if (mode == 1) begin
         tick(1'b1, rb(), rb(), 8'($urandom()));
         quiet("wabort");
         return;
      end
      tick(1'b0, rb(), 1'b1, txd);
      chk("miso_b7", 32'(MISO), 32'(txd[7]));
      for (int b = 1; b <= 8; b++) begin
         if (mode == 3 && b == k) begin
            #2 rst = 1'b1;
            #1;
            quiet("rst");
            chk("rst_rxd", 32'(rx_data), 32'd0);
            rd_seen = 1'b0;
            last_rx = '0;
            @(negedge clk);
            SS_n = 1'b1;
            rst  = 1'b0;
            return;
         end
         if (mode == 2 && b == k) begin
            tick(1'b1, rb(), rb(), 8'($urandom()));
            quiet("sabort");
            return;
         end
         tick(1'b0, rb(), rb(), 8'($urandom()));
         chk("miso_bit", 32'(MISO), b < 8 ? 32'(txd[7-b]) : 32'd0);
         chk("tx_rxv", 32'(rx_valid), 32'd0);
      end
      rd_seen = 1'b0;
      repeat ($urandom_range(0, 2)) begin
         tick(1'b0, rb(), rb(), 8'($urandom()));
         quiet("done");
      end
   endtask

   task automatic txn(input logic [9:0] frame, input int abort_bit,
                      input int stray, input int wait_d, input int mode,
                      input int k, input logic [7:0] txd);
      run_txn(frame, abort_bit, stray, wait_d, mode, k, txd);
      tick(1'b1, rb(), rb(), 8'($urandom()));
      quiet("gap");
      chk("gap_rxd", 32'(rx_data), 32'(last_rx));
   endtask

   initial begin
      logic [9:0] f;
      int         ab;
      int         st;
      int         md;
      rst      = 1'b1;
      SS_n     = 1'b1;
      MOSI     = 1'b0;
      tx_valid = 1'b0;
      tx_data  = '0;
      repeat (2) @(posedge clk);
      #1;
      quiet("reset");
      chk("reset_rxd", 32'(rx_data), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      txn(10'h00A, 10, -1, 0, 0, 0, 8'h00);
      txn(10'h205, 10, -1, 0, 0, 0, 8'h00);
      txn(10'h3FF, 10, -1, 1, 0, 0, 8'hA5);
      txn(10'h0F0, 5, -1, 0, 0, 0, 8'h00);
      txn(10'h155, 10, 4, 0, 0, 0, 8'h00);
      txn(10'h0AB, 9, -1, 0, 0, 0, 8'h00);
      txn(10'h200, 10, -1, 0, 0, 0, 8'h00);
      txn(10'h300, 10, 9, 0, 3, 3, 8'h5A);
      txn(10'h2AA, 10, -1, 0, 0, 0, 8'h00);
      txn(10'h3AA, 10, -1, 0, 0, 0, 8'h3C);
      txn(10'h201, 10, -1, 0, 0, 0, 8'h00);
      txn(10'h300, 10, -1, 2, 1, 0, 8'h00);
      txn(10'h311, 10, -1, 0, 0, 0, 8'hC3);

      for (int n = 0; n < 200; n++) begin
         f = 10'($urandom());
         if ($urandom() % 3 != 0) f[9] = 1'b1;
         ab = ($urandom() % 5 == 0) ? int'($urandom_range(0, 9)) : 10;
         st = ($urandom() % 3 == 0) ? int'($urandom_range(0, 9)) : -1;
         md = int'($urandom_range(0, 7));
         if (md > 3) md = 0;
         txn(f, ab, st, int'($urandom_range(0, 3)), md,
             int'($urandom_range(1, 7)), 8'($urandom()));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
